// File: rtl/fm_pkg.sv
// ---------------------------------------------------------------------------
// fm_pkg
// Shared definitions for the FM demodulator phase path:
//   - default fraction width and the pi/4, 3pi/4 angle constants at that width
//   - qpi_for(): round(pi/4 * 2^bits) for any fraction width
//   - state_t:   state encoding of the quadrant-arctan divider controller
//   - qarctan_ref(): plain-arithmetic angle reference used by the bench model
// ---------------------------------------------------------------------------
package fm_pkg;

   localparam int BITS_DEFAULT     = 10;
   localparam int QUARTER_PI       = 804;
   localparam int THREE_QUARTER_PI = 3 * QUARTER_PI;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CALC  = 3'd1,
      ST_REQ   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_SCALE = 3'd4,
      ST_OUT   = 3'd5
   } state_t;

   // round(pi/4 * 2^bits); yields 804 for bits = 10
   function automatic int qpi_for(input int bits);
      return $rtoi(0.78539816339744830962 * real'(longint'(1) << bits) + 0.5);
   endfunction

   // Quadrant arctan of (x, y) in Q(bits), worked with ordinary integer maths:
   // truncating ratio division, floor on the angle scaling, mirrored for y < 0.
   function automatic int qarctan_ref(input longint x, input longint y, input int bits);
      longint ay;
      longint num;
      longint den;
      longint base;
      longint ratio;
      longint prod;
      longint one;
      longint scaled;
      longint ang;
      one = longint'(1) << bits;
      ay  = ((y < 0) ? -y : y) + 1;
      if (x >= 0) begin
         num  = x - ay;
         den  = x + ay;
         base = qpi_for(bits);
      end else begin
         num  = x + ay;
         den  = ay - x;
         base = 3 * qpi_for(bits);
      end
      ratio  = (num * one) / den;
      prod   = qpi_for(bits) * ratio;
      scaled = prod / one;
      if ((prod % one) != 0 && prod < 0) begin
         scaled = scaled - 1;
      end else begin
         scaled = scaled;
      end
      ang = base - scaled;
      if (y < 0) begin
         ang = -ang;
      end else begin
         ang = ang;
      end
      return int'(ang);
   endfunction

endpackage

// File: rtl/qarctan_div_ctrl.sv
// ---------------------------------------------------------------------------
// qarctan_div_ctrl
// Phase stage in front of the shared iterative divider. Takes one I/Q pair,
// forms the signed ratio (x -/+ |y|) / (x +/- |y|) scaled by 2^BITS, hands it
// to the divider, and turns the quotient into a Q(BITS) angle for the FM
// discriminator.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_valid/in_ready   sample handshake; in_ready high only when idle
//   in_x, in_y          signed I and Q samples (DATA_WIDTH)
//   div_valid           one-cycle request pulse to the divider
//   div_dividend        signed dividend, held until div_done
//   div_divisor         signed divisor, held until div_done
//   div_quotient        divider quotient (low 32 bits used)
//   div_done            divider result strobe (only honoured while waiting)
//   div_overflow        divider overflow flag
//   out_valid/out_ready angle handshake toward the discriminator
//   out_angle           signed Q(BITS) angle, roughly +/- pi * 2^BITS
//   out_err             divider overflowed for this sample (angle forced 0)
// ---------------------------------------------------------------------------
module qarctan_div_ctrl
   import fm_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int BITS           = BITS_DEFAULT,
   parameter int DIVIDEND_WIDTH = 64,
   parameter int DIVISOR_WIDTH  = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     in_x,
   input  logic [DATA_WIDTH-1:0]     in_y,
   output logic                      div_valid,
   output logic [DIVIDEND_WIDTH-1:0] div_dividend,
   output logic [DIVISOR_WIDTH-1:0]  div_divisor,
   input  logic [DIVIDEND_WIDTH-1:0] div_quotient,
   input  logic                      div_done,
   input  logic                      div_overflow,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [31:0]               out_angle,
   output logic                      out_err
);

   localparam logic signed [31:0] QPI_C  = 32'(qpi_for(BITS));
   localparam logic signed [31:0] TQPI_C = 32'(3 * qpi_for(BITS));

   state_t                      state_q, state_d;
   logic signed [31:0]          x_q, x_d;
   logic signed [31:0]          y_q, y_d;
   logic signed [31:0]          base_q, base_d;
   logic [DIVIDEND_WIDTH-1:0]   dividend_q, dividend_d;
   logic [DIVISOR_WIDTH-1:0]    divisor_q, divisor_d;
   logic signed [31:0]          r_q, r_d;
   logic                        err_q, err_d;
   logic [31:0]                 angle_q, angle_d;
   logic                        in_ready_q, in_ready_d;
   logic                        div_valid_q, div_valid_d;
   logic                        out_valid_q, out_valid_d;

   // Ratio operands: |y| + 1 keeps the denominator strictly positive, so the
   // divider never sees a zero or -1 divisor.
   logic signed [31:0]               abs_y_s;
   logic signed [31:0]               num_s;
   logic signed [31:0]               den_s;
   logic signed [DIVIDEND_WIDTH-1:0] num_ext_s;
   logic signed [DIVIDEND_WIDTH-1:0] num_shift_s;

   assign abs_y_s     = (y_q[31] ? -y_q : y_q) + 32'sd1;
   assign num_s       = x_q[31] ? (x_q + abs_y_s) : (x_q - abs_y_s);
   assign den_s       = x_q[31] ? (abs_y_s - x_q) : (x_q + abs_y_s);
   assign num_ext_s   = {{(DIVIDEND_WIDTH-32){num_s[31]}}, num_s};
   assign num_shift_s = num_ext_s <<< BITS;

   // Angle scaling: base - floor(pi/4 * r / 2^BITS), mirrored for negative Q.
   logic signed [31:0] prod_s;
   logic signed [31:0] scaled_s;
   logic signed [31:0] ang_raw_s;
   logic signed [31:0] ang_s;

   assign prod_s    = QPI_C * r_q;
   assign scaled_s  = prod_s >>> BITS;
   assign ang_raw_s = base_q - scaled_s;
   assign ang_s     = y_q[31] ? -ang_raw_s : ang_raw_s;

   // |r| <= 2^BITS, so the quotient's upper half carries only sign copies.
   logic unused_quot_hi;
   assign unused_quot_hi = ^div_quotient[DIVIDEND_WIDTH-1:32];

   // Next-state and datapath register updates for the controller FSM.
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      base_d    = base_q;
      dividend_d = dividend_q;
      divisor_d = divisor_q;
      r_d       = r_q;
      err_d     = err_q;
      angle_d   = angle_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               x_d     = {{(32-DATA_WIDTH){in_x[DATA_WIDTH-1]}}, in_x};
               y_d     = {{(32-DATA_WIDTH){in_y[DATA_WIDTH-1]}}, in_y};
               state_d = ST_CALC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            dividend_d = num_shift_s;
            divisor_d  = DIVISOR_WIDTH'(den_s);
            if (x_q[31]) begin
               base_d = TQPI_C;
            end else begin
               base_d = QPI_C;
            end
            state_d = ST_REQ;
         end
         ST_REQ: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // Operands stay untouched here; the divider keeps reading them.
            if (div_done) begin
               r_d     = div_quotient[31:0];
               err_d   = div_overflow;
               state_d = ST_SCALE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_SCALE: begin
            if (err_q) begin
               angle_d = 32'd0;
            end else begin
               angle_d = ang_s;
            end
            state_d = ST_OUT;
         end
         ST_OUT: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_OUT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Handshake outputs are registered copies decoded from the next state.
      in_ready_d  = (state_d == ST_IDLE);
      div_valid_d = (state_d == ST_REQ);
      out_valid_d = (state_d == ST_OUT);
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         x_q         <= 32'sd0;
         y_q         <= 32'sd0;
         base_q      <= 32'sd0;
         dividend_q  <= {DIVIDEND_WIDTH{1'b0}};
         divisor_q   <= {DIVISOR_WIDTH{1'b0}};
         r_q         <= 32'sd0;
         err_q       <= 1'b0;
         angle_q     <= 32'd0;
         in_ready_q  <= 1'b1;
         div_valid_q <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         base_q      <= base_d;
         dividend_q  <= dividend_d;
         divisor_q   <= divisor_d;
         r_q         <= r_d;
         err_q       <= err_d;
         angle_q     <= angle_d;
         in_ready_q  <= in_ready_d;
         div_valid_q <= div_valid_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign div_valid    = div_valid_q;
   assign div_dividend = dividend_q;
   assign div_divisor  = divisor_q;
   assign out_valid    = out_valid_q;
   assign out_angle    = angle_q;
   assign out_err      = err_q;

endmodule

// File: tb/tb_qarctan_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_qarctan_div_ctrl
// Self-checking bench: directed vector table with hand-derived operands and
// angles, randomized samples against fm_pkg::qarctan_ref, and sequences for
// back-pressure, reset while waiting on the divider, overflow and stray
// div_done pulses. A behavioural divider with variable latency sits beside
// the DUT.
// ---------------------------------------------------------------------------
module tb_qarctan_div_ctrl;
   import fm_pkg::*;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_x;
   logic [DW-1:0] in_y;
   logic          div_valid;
   logic [63:0]   div_dividend;
   logic [31:0]   div_divisor;
   logic [63:0]   div_quotient;
   logic          div_done;
   logic          div_overflow;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_angle;
   logic          out_err;

   qarctan_div_ctrl #(.DATA_WIDTH(DW), .BITS(10), .DIVIDEND_WIDTH(64), .DIVISOR_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
      .div_valid(div_valid), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_done(div_done), .div_overflow(div_overflow),
      .out_valid(out_valid), .out_ready(out_ready), .out_angle(out_angle), .out_err(out_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural divider ----------------
   bit     rand_lat  = 1'b1;
   int     fixed_lat = 3;
   bit     force_ovf = 1'b0;
   bit     spur_req  = 1'b0;
   int     req_count = 0;
   longint last_dividend = 0;
   longint last_divisor  = 0;

   initial begin
      int cnt;
      cnt          = 0;
      div_done     = 1'b0;
      div_overflow = 1'b0;
      div_quotient = 64'd0;
      forever begin
         @(negedge clk);
         div_done     = 1'b0;
         div_overflow = 1'b0;
         if (reset) begin
            cnt = 0;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               div_quotient = $signed(div_dividend) / longint'($signed(div_divisor));
               div_overflow = force_ovf;
               div_done     = 1'b1;
            end
         end else if (div_valid) begin
            cnt           = rand_lat ? int'($urandom_range(1, 6)) : fixed_lat;
            last_dividend = $signed(div_dividend);
            last_divisor  = longint'($signed(div_divisor));
            req_count++;
         end else if (spur_req) begin
            div_quotient = 64'd123;
            div_overflow = 1'b1;
            div_done     = 1'b1;
            spur_req     = 1'b0;
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic send(input int x, input int y);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", in_ready, 1);
      in_x     = DW'(x);
      in_y     = DW'(y);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic get_out(input int stall, output logic signed [31:0] ang, output logic err);
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("out_valid_wait", out_valid, 1);
      ang = out_angle;
      err = out_err;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_drop", out_valid, 0);
   endtask

   typedef struct {
      int     x;
      int     y;
      longint dividend;
      longint divisor;
      int     angle;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic signed [31:0] ang;
      logic               err;
      int                 saved_req;
      logic signed [15:0] rx;
      logic signed [15:0] ry;

      vecs[0] = '{1000,      0,  999 * 1024, 1001,     3};
      vecs[1] = '{0,      1000, -1001 * 1024, 1001,  1608};
      vecs[2] = '{-1000,     0, -999 * 1024, 1001,  3214};
      vecs[3] = '{0,     -1000, -1001 * 1024, 1001, -1608};
      vecs[4] = '{1,         1,       -1024,    3,  1072};
      vecs[5] = '{-1,       -1,        1024,    3, -2145};
      vecs[6] = '{-32768, -32768,      1024, 65537, -2412};
      vecs[7] = '{32767,  -32768,     -2048, 65536,  -804};

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_x      = '0;
      in_y      = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);

      // reset state
      check("rst_in_ready",  in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_div_valid", div_valid, 0);
      check("rst_angle",     out_angle, 0);
      check("rst_err",       out_err, 0);
      check("rst_dividend",  div_dividend, 0);
      check("rst_divisor",   div_divisor, 0);
      reset = 1'b0;
      @(negedge clk);

      // directed table
      for (int i = 0; i < 8; i++) begin
         send(vecs[i].x, vecs[i].y);
         get_out(i % 3, ang, err);
         check($sformatf("vec%0d_dividend", i), last_dividend, vecs[i].dividend);
         check($sformatf("vec%0d_divisor", i),  last_divisor,  vecs[i].divisor);
         check($sformatf("vec%0d_angle", i),    ang, vecs[i].angle);
         check($sformatf("vec%0d_err", i),      err, 0);
      end

      // randomized samples against the reference model
      for (int i = 0; i < 40; i++) begin
         rx = 16'($urandom);
         ry = 16'($urandom);
         send(int'(rx), int'(ry));
         get_out(int'($urandom_range(0, 3)), ang, err);
         check($sformatf("rnd%0d_angle", i), ang, qarctan_ref(longint'(rx), longint'(ry), 10));
         check($sformatf("rnd%0d_err", i),   err, 0);
      end

      // back-pressure: output held, second sample refused
      send(0, -1000);
      begin
         int n;
         n = 0;
         while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
         end
      end
      saved_req = req_count;
      in_x      = DW'(5);
      in_y      = DW'(5);
      in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", out_valid, 1);
         check("bp_angle",     $signed(out_angle), -1608);
         check("bp_in_ready",  in_ready, 0);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_drop", out_valid, 0);
      check("bp_idle", in_ready, 1);
      repeat (12) @(negedge clk);
      check("bp_no_second_req", req_count, saved_req);
      check("bp_no_second_out", out_valid, 0);

      // reset while waiting on the divider
      rand_lat  = 1'b0;
      fixed_lat = 20;
      saved_req = req_count;
      send(500, 500);
      begin
         int n;
         n = 0;
         while (req_count == saved_req && n < 50) begin
            @(negedge clk);
            n++;
         end
      end
      check("rw_req_seen", req_count, saved_req + 1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rw_in_ready",  in_ready, 1);
      check("rw_out_valid", out_valid, 0);
      check("rw_div_valid", div_valid, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (25) @(negedge clk);
      check("rw_no_output", out_valid, 0);
      rand_lat = 1'b1;
      send(1000, 0);
      get_out(0, ang, err);
      check("rw_after_angle", ang, 3);
      check("rw_after_err",   err, 0);

      // divider overflow reported
      force_ovf = 1'b1;
      send(1000, 0);
      get_out(2, ang, err);
      force_ovf = 1'b0;
      check("ovf_err",   err, 1);
      check("ovf_angle", ang, 0);

      // stray div_done while idle is ignored
      spur_req = 1'b1;
      repeat (3) @(negedge clk);
      check("spur_no_out", out_valid, 0);
      check("spur_idle",   in_ready, 1);
      send(0, 1000);
      get_out(0, ang, err);
      check("spur_angle", ang, 1608);
      check("spur_err",   err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
